// File: rtl/text_line_engine.sv
// text_line_engine: text-mode VGA renderer.
// A fetch engine walks one scanline worth of character cells over a simple
// bus master port, looks up the glyph row in an external synchronous font
// ROM, and writes {bg, fg, glyph bits} into one half of a ping-pong line
// buffer. The display side reads the other half on every pixel strobe and
// produces a registered RRRGGGBB-expanded colour.
//
// state | meaning
// IDLE  | waiting for line_fetch_i (or a restart after an aborted fetch)
// BUS   | cyc_o high, address stable, waiting for ack_i
// FONT  | font address presented, waiting one clock for the ROM
// STORE | write cell into the line buffer, advance column or finish
module text_line_engine #(
    parameter int COLS    = 80,
    parameter int ROWS    = 60,
    parameter int FONT_H  = 8,
    parameter int BLINK_W = 25
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pix_en_i,
    input  logic [10:0] x_i,
    input  logic [10:0] y_i,
    input  logic        line_fetch_i,
    input  logic [10:0] line_y_i,
    input  logic [31:0] base_i,
    input  logic [7:0]  cursor_row_i,
    input  logic [7:0]  cursor_col_i,
    input  logic [1:0]  cursormode_i,
    output logic        cyc_o,
    output logic [31:0] adr_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    output logic [11:0] font_adr_o,
    input  logic [7:0]  font_dat_i,
    output logic [7:0]  r_o,
    output logic [7:0]  g_o,
    output logic [7:0]  b_o,
    output logic        busy_o,
    output logic        overrun_o
);

    localparam int FSH = $clog2(FONT_H);
    localparam int CW  = $clog2(COLS);

    typedef enum logic [1:0] {IDLE, BUS, FONT, STORE} state_t;

    state_t               state;
    logic [10:0]          line_y;
    logic [CW-1:0]        col;
    logic                 restart;
    logic [7:0]           cell_bg;
    logic [7:0]           cell_fg;
    logic                 cell_ul;
    logic                 cell_blk;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 blink;

    logic [23:0]          bank0 [COLS];
    logic [23:0]          bank1 [COLS];

    logic                 abort;
    logic [10:0]          start_y;
    logic [23:0]          store_entry;
    logic                 store_last_row;

    logic                 unused_flags;
    assign unused_flags = ^dat_i[15:10];

    assign blink   = blink_cnt[BLINK_W-1];
    assign abort   = line_fetch_i && busy_o;
    assign start_y = line_fetch_i ? line_y_i : line_y;

    // Byte address of cell (text row of ly, column c) in the character map.
    function automatic logic [31:0] cell_adr(input logic [10:0] ly, input logic [CW-1:0] c);
        logic [31:0] row;
        row = 32'(ly >> FSH);
        return base_i + ((row * COLS + 32'(c)) << 2);
    endfunction

    // Free-running blink counter; its MSB is the blink phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) blink_cnt <= '0;
        else         blink_cnt <= blink_cnt + BLINK_W'(1);
    end

    // Fetch sequencer: bus read, font lookup, store; abort on a new request while busy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            line_y     <= '0;
            col        <= '0;
            restart    <= 1'b0;
            cyc_o      <= 1'b0;
            adr_o      <= '0;
            font_adr_o <= '0;
            busy_o     <= 1'b0;
            overrun_o  <= 1'b0;
            cell_bg    <= '0;
            cell_fg    <= '0;
            cell_ul    <= 1'b0;
            cell_blk   <= 1'b0;
        end else if (abort) begin
            overrun_o <= 1'b1;
            line_y    <= line_y_i;
            col       <= '0;
            cyc_o     <= 1'b0;
            restart   <= 1'b1;
            state     <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (line_fetch_i || restart) begin
                        line_y  <= start_y;
                        col     <= '0;
                        adr_o   <= cell_adr(start_y, '0);
                        cyc_o   <= 1'b1;
                        busy_o  <= 1'b1;
                        restart <= 1'b0;
                        state   <= BUS;
                    end
                end
                BUS: begin
                    if (ack_i) begin
                        cell_bg    <= dat_i[31:24];
                        cell_fg    <= dat_i[23:16];
                        cell_ul    <= dat_i[9];
                        cell_blk   <= dat_i[8];
                        font_adr_o <= {dat_i[7:0], 4'(line_y[FSH-1:0])};
                        cyc_o      <= 1'b0;
                        state      <= FONT;
                    end
                end
                FONT: state <= STORE;
                STORE: begin
                    if (col == CW'(COLS - 1)) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        col   <= col + CW'(1);
                        adr_o <= cell_adr(line_y, col + CW'(1));
                        cyc_o <= 1'b1;
                        state <= BUS;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Cell entry as written to the line buffer: underline and blink resolved here.
    always_comb begin
        store_last_row = (line_y[FSH-1:0] == FSH'(FONT_H - 1));
        store_entry    = {cell_bg, cell_fg, font_dat_i};
        if (cell_blk && !blink) store_entry[15:8] = cell_bg;
        if (cell_ul && store_last_row) store_entry[7:0] = 8'hFF;
    end

    // Line buffer write; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (state == STORE && !abort) begin
            if (line_y[0]) bank1[col] <= store_entry;
            else           bank0[col] <= store_entry;
        end
    end

    logic          in_area;
    logic [7:0]    cell_x;
    logic [10:0]   text_row;
    logic [CW-1:0] rd_idx;
    logic [23:0]   rd_entry;
    logic [2:0]    bit_sel;
    logic          pix_bit;
    logic          is_cursor;
    logic          last_row;
    logic [7:0]    colour;

    // Display path: pick the buffer entry and decide the 8-bit colour for this pixel.
    always_comb begin
        in_area   = (x_i < 11'(COLS * 8)) && (y_i < 11'(ROWS * FONT_H));
        cell_x    = x_i[10:3];
        text_row  = y_i >> FSH;
        rd_idx    = in_area ? CW'(cell_x) : '0;
        rd_entry  = y_i[0] ? bank1[rd_idx] : bank0[rd_idx];
        bit_sel   = 3'd7 - x_i[2:0];
        pix_bit   = rd_entry[bit_sel];
        is_cursor = (text_row == 11'(cursor_row_i)) && (cell_x == cursor_col_i);
        last_row  = (y_i[FSH-1:0] == FSH'(FONT_H - 1));
        colour    = pix_bit ? rd_entry[15:8] : rd_entry[23:16];
        if (is_cursor) begin
            case (cursormode_i)
                2'd1:    if (blink) colour = rd_entry[15:8];
                2'd2:    colour = rd_entry[15:8];
                2'd3:    if (blink && last_row) colour = rd_entry[15:8];
                default: ;
            endcase
        end
        if (!in_area) colour = 8'h00;
    end

    // Registered RGB, zero-fill expansion of RRRGGGBB; held between strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_o <= '0;
            g_o <= '0;
            b_o <= '0;
        end else if (pix_en_i) begin
            r_o <= {colour[7:5], 5'b0};
            g_o <= {colour[4:2], 5'b0};
            b_o <= {colour[1:0], 6'b0};
        end
    end

endmodule

// File: tb/tb_text_line_engine.sv
// Directed bench for text_line_engine: bus slave with one wait cycle,
// synchronous font ROM, blink phase tracked by a local cycle counter.
module tb_text_line_engine;

    localparam int COLS    = 80;
    localparam int ROWS    = 60;
    localparam int FONT_H  = 8;
    localparam int BLINK_W = 4;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [23:0] FG   = 24'hE0_00_00;
    localparam logic [23:0] BG   = 24'h00_E0_00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic [10:0] x = '0;
    logic [10:0] y = '0;
    logic        line_fetch = 1'b0;
    logic [10:0] line_y = '0;
    logic [7:0]  cursor_row = '0;
    logic [7:0]  cursor_col = '0;
    logic [1:0]  cursormode = '0;
    logic        cyc;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        ack;
    logic [11:0] font_adr;
    logic [7:0]  font_dat;
    logic [7:0]  r, g, b;
    logic        busy;
    logic        overrun;

    int errors = 0;
    int checks = 0;
    int unsigned tick;
    logic [31:0] mem [0:4095];
    logic [31:0] acks [$];

    text_line_engine #(.COLS(COLS), .ROWS(ROWS), .FONT_H(FONT_H), .BLINK_W(BLINK_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .pix_en_i(pix_en), .x_i(x), .y_i(y),
        .line_fetch_i(line_fetch), .line_y_i(line_y), .base_i(BASE),
        .cursor_row_i(cursor_row), .cursor_col_i(cursor_col), .cursormode_i(cursormode),
        .cyc_o(cyc), .adr_o(adr), .dat_i(dat), .ack_i(ack),
        .font_adr_o(font_adr), .font_dat_i(font_dat),
        .r_o(r), .g_o(g), .b_o(b), .busy_o(busy), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack <= 1'b0;
            dat <= '0;
        end else begin
            ack <= cyc && !ack;
            dat <= mem[12'((adr - BASE) >> 2)];
        end
    end

    function automatic logic [7:0] glyph(input logic [11:0] a);
        if (a[11:4] == 8'h41) return (a[3:0] == 4'd7) ? 8'h00 : 8'h18;
        return 8'h00;
    endfunction

    always @(posedge clk) font_dat <= glyph(font_adr);

    always @(posedge clk) if (cyc && ack) acks.push_back(adr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick <= 0;
        else        tick <= tick + 1;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [10:0] ly, output int dur);
        acks.delete();
        line_y = ly;
        line_fetch = 1'b1;
        step();
        line_fetch = 1'b0;
        dur = 0;
        while (busy && dur < 2000) begin
            step();
            dur++;
        end
    endtask

    task automatic pix(input logic [10:0] px, input logic [10:0] py, output logic [23:0] rgb);
        x = px;
        y = py;
        pix_en = 1'b1;
        step();
        pix_en = 1'b0;
        rgb = {r, g, b};
    endtask

    task automatic wait_blink(input logic want);
        int n = 0;
        while (tick[3] != want && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic check_seq(input string tag, input logic [31:0] first);
        logic ok = 1'b1;
        foreach (acks[i]) if (acks[i] !== first + 32'(i * 4)) ok = 1'b0;
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int dur;
        int n;
        logic [23:0] rgb;

        for (int i = 0; i < 4096; i++) mem[i] = 32'h1C_E0_00_41;
        for (int c = 0; c < COLS; c++) mem[COLS + c] = 32'h1C_E0_02_41;

        // Reset state
        step();
        step();
        check("rst_cyc", 32'(cyc), 0);
        check("rst_adr", adr, 0);
        check("rst_font_adr", 32'(font_adr), 0);
        check("rst_rgb", {8'h0, r, g, b}, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        step();

        // Line 0 fetch: 80 cells, 4 clocks each
        fetch(11'd0, dur);
        check("l0_count", acks.size(), 80);
        check("l0_first", acks.size() > 0 ? acks[0] : 32'hDEAD, 32'h1000);
        check("l0_last", acks.size() > 79 ? acks[79] : 32'hDEAD, 32'h113C);
        check_seq("l0_seq", 32'h1000);
        check("l0_busy_clks", dur, 320);
        check("l0_overrun", 32'(overrun), 0);

        // Pixels on line 0: glyph row 0x18, fg E0, bg 1C
        cursor_row = 8'd2;
        cursor_col = 8'd5;
        cursormode = 2'd0;
        pix(11'd3, 11'd0, rgb);   check("px_x3", 32'(rgb), 32'(FG));
        pix(11'd4, 11'd0, rgb);   check("px_x4", 32'(rgb), 32'(FG));
        pix(11'd0, 11'd0, rgb);   check("px_x0", 32'(rgb), 32'(BG));
        pix(11'd5, 11'd0, rgb);   check("px_x5", 32'(rgb), 32'(BG));
        pix(11'd640, 11'd0, rgb); check("px_xout", 32'(rgb), 0);
        pix(11'd3, 11'd480, rgb); check("px_yout", 32'(rgb), 0);

        // Line 15: text row 1, glyph row 7, underlined cells
        fetch(11'd15, dur);
        check("l15_first", acks.size() > 0 ? acks[0] : 32'hDEAD, BASE + 32'd320);
        check("l15_busy_clks", dur, 320);
        pix(11'd0, 11'd15, rgb);  check("ul_x0", 32'(rgb), 32'(FG));
        pix(11'd7, 11'd15, rgb);  check("ul_x7", 32'(rgb), 32'(FG));
        pix(11'd13, 11'd15, rgb); check("ul_x13", 32'(rgb), 32'(FG));
        fetch(11'd8, dur);
        pix(11'd0, 11'd8, rgb);   check("ul_row0_x0", 32'(rgb), 32'(BG));
        pix(11'd3, 11'd8, rgb);   check("ul_row0_x3", 32'(rgb), 32'(FG));

        // Cursor at (2,5): line 16 is glyph row 0, pixel x=40 is a 0 bit
        fetch(11'd16, dur);
        pix(11'd40, 11'd16, rgb); check("cur_m0", 32'(rgb), 32'(BG));
        cursormode = 2'd2;
        pix(11'd40, 11'd16, rgb); check("cur_m2", 32'(rgb), 32'(FG));
        pix(11'd48, 11'd16, rgb); check("cur_m2_other", 32'(rgb), 32'(BG));
        cursormode = 2'd1;
        wait_blink(1'b1);
        pix(11'd40, 11'd16, rgb); check("cur_m1_on", 32'(rgb), 32'(FG));
        wait_blink(1'b0);
        pix(11'd40, 11'd16, rgb); check("cur_m1_off", 32'(rgb), 32'(BG));
        cursormode = 2'd3;
        wait_blink(1'b1);
        pix(11'd40, 11'd16, rgb); check("cur_m3_row0", 32'(rgb), 32'(BG));
        fetch(11'd23, dur);
        wait_blink(1'b1);
        pix(11'd40, 11'd23, rgb); check("cur_m3_on", 32'(rgb), 32'(FG));
        wait_blink(1'b0);
        pix(11'd40, 11'd23, rgb); check("cur_m3_off", 32'(rgb), 32'(BG));
        cursormode = 2'd0;

        // Overrun: new request after 40 cells of line 0
        acks.delete();
        line_y = 11'd0;
        line_fetch = 1'b1;
        step();
        line_fetch = 1'b0;
        n = 0;
        while (acks.size() < 40 && n < 1000) begin
            step();
            n++;
        end
        check("ovr_acks40", acks.size(), 40);
        acks.delete();
        line_y = 11'd24;
        line_fetch = 1'b1;
        step();
        line_fetch = 1'b0;
        check("ovr_set", 32'(overrun), 1);
        check("ovr_cyc_low", 32'(cyc), 0);
        dur = 0;
        while (busy && dur < 2000) begin
            step();
            dur++;
        end
        check("ovr_busy_clks", dur, 321);
        check("ovr_first", acks.size() > 0 ? acks[0] : 32'hDEAD, BASE + 32'd960);
        check("ovr_count", acks.size(), 80);
        check_seq("ovr_seq", BASE + 32'd960);
        step();
        check("ovr_sticky", 32'(overrun), 1);

        // Reset during a bus wait
        acks.delete();
        line_y = 11'd0;
        line_fetch = 1'b1;
        step();
        line_fetch = 1'b0;
        check("rb_cyc_before", 32'(cyc), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rb_cyc_async", 32'(cyc), 0);
        check("rb_busy", 32'(busy), 0);
        check("rb_overrun", 32'(overrun), 0);
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        check("rb_idle_cyc", 32'(cyc), 0);
        check("rb_idle_busy", 32'(busy), 0);
        fetch(11'd0, dur);
        check("rb_refetch_first", acks.size() > 0 ? acks[0] : 32'hDEAD, 32'h1000);
        check("rb_refetch_clks", dur, 320);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
